// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer: FSM encoding, pattern
// count, result widths and the per-index compare helper.
package truth_table_sequencer_pkg;

  // Sweep controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Number of input combinations of the 3-input circuit.
  localparam int NUM_PATTERNS = 8;

  // Last index of a sweep. Reaching it ends the sweep instead of incrementing.
  localparam logic [2:0] LAST_IDX = 3'(NUM_PATTERNS - 1);

  // The error count must hold 0..8, so it needs 4 bits.
  typedef logic [3:0] err_cnt_t;
  typedef logic [7:0] fail_vec_t;

  // High when either observed output differs from its expected table entry.
  function automatic logic idx_mismatch(
    input logic [7:0] exp_d,
    input logic [7:0] exp_e,
    input logic [2:0] idx,
    input logic       d,
    input logic       e
  );
    return (d != exp_d[idx]) || (e != exp_e[idx]);
  endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Pin bundle between the sequencer and its environment: the start/result side
// and the drive/observe pins of the circuit being exercised.
interface truth_table_sequencer_if;
  import truth_table_sequencer_pkg::*;

  logic      start;
  logic      d_in;
  logic      e_in;
  logic      a_out;
  logic      b_out;
  logic      c_out;
  logic      busy;
  logic      done;
  logic      pass;
  err_cnt_t  err_count;
  fail_vec_t fail_vec;

  // Sequencer side.
  modport master (
    input  start, d_in, e_in,
    output a_out, b_out, c_out, busy, done, pass, err_count, fail_vec
  );

  // Environment side: issues start, supplies circuit outputs, sees results.
  modport slave (
    output start, d_in, e_in,
    input  a_out, b_out, c_out, busy, done, pass, err_count, fail_vec
  );

endinterface

// File: rtl/truth_table_sequencer_hold_timer.sv
// Loadable down-counter that paces each input combination. The expiry flag is
// registered and tracks "count is zero" without a combinational decode.
module hold_timer
  import truth_table_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expired
);

  logic [7:0] count_r;
  logic       expired_r;

  // Load, decrement toward zero, then sit at zero; expiry follows the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r   <= 8'd0;
      expired_r <= 1'b1;
    end else if (load) begin
      count_r   <= load_val;
      expired_r <= (load_val == 8'd0);
    end else if (count_r != 8'd0) begin
      count_r   <= count_r - 8'd1;
      expired_r <= (count_r == 8'd1);
    end else begin
      count_r   <= count_r;
      expired_r <= 1'b1;
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/truth_table_sequencer.sv
// Clocked stimulus controller: walks {A,B,C} through 0..7, holds each
// combination for HOLD_CYCLES cycles, samples D/E once and records mismatches
// against the expected truth tables.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int         HOLD_CYCLES = 20,
  parameter logic [7:0] EXP_D       = 8'h00,
  parameter logic [7:0] EXP_E       = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  truth_table_sequencer_if.master    bus
);

  // Reload value: the counter runs HOLD_CYCLES-1 down to 0, one APPLY cycle each.
  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  state_t    state_r;
  logic [2:0] idx_r;
  logic      busy_r;
  logic      done_r;
  logic      pass_r;
  err_cnt_t  err_count_r;
  fail_vec_t fail_vec_r;

  logic      timer_load_s;
  logic      timer_expired_s;
  logic      mismatch_s;
  err_cnt_t  err_next_s;
  fail_vec_t fail_next_s;

  hold_timer u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load_s),
    .load_val (HOLD_RELOAD),
    .expired  (timer_expired_s)
  );

  // Compare the observed outputs of the current index and form updated results.
  always_comb begin
    mismatch_s  = idx_mismatch(EXP_D, EXP_E, idx_r, bus.d_in, bus.e_in);
    err_next_s  = err_count_r;
    fail_next_s = fail_vec_r;
    if (mismatch_s) begin
      err_next_s  = err_count_r + 4'd1;
      fail_next_s = fail_vec_r | (8'd1 << idx_r);
    end else begin
      err_next_s  = err_count_r;
      fail_next_s = fail_vec_r;
    end
  end

  // Reload the hold timer when a sweep starts and when moving to the next index.
  always_comb begin
    timer_load_s = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          timer_load_s = 1'b1;
        end else begin
          timer_load_s = 1'b0;
        end
      end
      S_SAMPLE: begin
        if (idx_r != LAST_IDX) begin
          timer_load_s = 1'b1;
        end else begin
          timer_load_s = 1'b0;
        end
      end
      default: timer_load_s = 1'b0;
    endcase
  end

  // Sweep FSM with index and result registers; start is honoured only when not busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= 3'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_count_r <= 4'd0;
      fail_vec_r  <= 8'd0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_r     <= S_APPLY;
            idx_r       <= 3'd0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_count_r <= 4'd0;
            fail_vec_r  <= 8'd0;
          end
        end
        S_APPLY: begin
          if (timer_expired_s) begin
            state_r <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          err_count_r <= err_next_s;
          fail_vec_r  <= fail_next_s;
          if (idx_r == LAST_IDX) begin
            // idx stays at 7 so the circuit keeps seeing 3'b111 while done.
            state_r <= S_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_next_s == 4'd0);
          end else begin
            state_r <= S_APPLY;
            idx_r   <= idx_r + 3'd1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          idx_r       <= 3'd0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          pass_r      <= 1'b0;
          err_count_r <= 4'd0;
          fail_vec_r  <= 8'd0;
        end
      endcase
    end
  end

  assign bus.a_out     = idx_r[2];
  assign bus.b_out     = idx_r[1];
  assign bus.c_out     = idx_r[0];
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.err_count = err_count_r;
  assign bus.fail_vec  = fail_vec_r;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: three sequencer instances around the stub D=A&B, E=A^B^C,
// driven by a table of sweeps plus hand-written reset/start corner sequences.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  truth_table_sequencer_if bus0 ();
  truth_table_sequencer_if bus1 ();
  truth_table_sequencer_if bus2 ();

  // 0: matching tables, hold 20; 1: faulty tables, hold 20; 2: matching, hold 1
  truth_table_sequencer #(.HOLD_CYCLES(20), .EXP_D(8'hC0), .EXP_E(8'h96))
    u0 (.clk(clk), .rst(rst), .bus(bus0));
  truth_table_sequencer #(.HOLD_CYCLES(20), .EXP_D(8'hC1), .EXP_E(8'h16))
    u1 (.clk(clk), .rst(rst), .bus(bus1));
  truth_table_sequencer #(.HOLD_CYCLES(1), .EXP_D(8'hC0), .EXP_E(8'h96))
    u2 (.clk(clk), .rst(rst), .bus(bus2));

  // Circuit stubs
  assign bus0.d_in = bus0.a_out & bus0.b_out;
  assign bus0.e_in = bus0.a_out ^ bus0.b_out ^ bus0.c_out;
  assign bus1.d_in = bus1.a_out & bus1.b_out;
  assign bus1.e_in = bus1.a_out ^ bus1.b_out ^ bus1.c_out;
  assign bus2.d_in = bus2.a_out & bus2.b_out;
  assign bus2.e_in = bus2.a_out ^ bus2.b_out ^ bus2.c_out;

  logic       start_v [3];
  logic [2:0] abc_v   [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       pass_v  [3];
  logic [3:0] err_v   [3];
  logic [7:0] fail_v  [3];

  assign bus0.start = start_v[0];
  assign bus1.start = start_v[1];
  assign bus2.start = start_v[2];
  assign abc_v[0]  = {bus0.a_out, bus0.b_out, bus0.c_out};
  assign abc_v[1]  = {bus1.a_out, bus1.b_out, bus1.c_out};
  assign abc_v[2]  = {bus2.a_out, bus2.b_out, bus2.c_out};
  assign busy_v[0] = bus0.busy;
  assign busy_v[1] = bus1.busy;
  assign busy_v[2] = bus2.busy;
  assign done_v[0] = bus0.done;
  assign done_v[1] = bus1.done;
  assign done_v[2] = bus2.done;
  assign pass_v[0] = bus0.pass;
  assign pass_v[1] = bus1.pass;
  assign pass_v[2] = bus2.pass;
  assign err_v[0]  = bus0.err_count;
  assign err_v[1]  = bus1.err_count;
  assign err_v[2]  = bus2.err_count;
  assign fail_v[0] = bus0.fail_vec;
  assign fail_v[1] = bus1.fail_vec;
  assign fail_v[2] = bus2.fail_vec;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    int         inst;
    int         hold;
    int         start_again_at;  // edge count after start for a stray start, -1 = none
    int         exp_done;        // edges from start edge until done is seen
    logic [3:0] exp_err;
    logic [7:0] exp_fail;
    logic       exp_pass;
  } sweep_t;

  task automatic check_all_zero(input int i, input string tag);
    check({tag, "_abc"},  int'(abc_v[i]),  0);
    check({tag, "_busy"}, int'(busy_v[i]), 0);
    check({tag, "_done"}, int'(done_v[i]), 0);
    check({tag, "_pass"}, int'(pass_v[i]), 0);
    check({tag, "_err"},  int'(err_v[i]),  0);
    check({tag, "_fail"}, int'(fail_v[i]), 0);
  endtask

  // Pulse start, follow every cycle of the sweep, then check the final results.
  task automatic run_sweep(input sweep_t v);
    int i = v.inst;
    int k = 0;
    int done_at = -1;
    int seq_err = 0;
    int limit = 8 * (v.hold + 1) + 10;
    int exp_idx;
    @(negedge clk);
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    // Results clear and busy rises on the accepted start edge
    check("start_busy", int'(busy_v[i]), 1);
    check("start_done", int'(done_v[i]), 0);
    check("start_pass", int'(pass_v[i]), 0);
    check("start_err",  int'(err_v[i]),  0);
    check("start_fail", int'(fail_v[i]), 0);
    while (done_at < 0 && k <= limit) begin
      if (done_v[i]) begin
        done_at = k;
      end else begin
        exp_idx = k / (v.hold + 1);
        if (busy_v[i] !== 1'b1 || int'(abc_v[i]) != exp_idx) seq_err++;
        if (k == v.start_again_at) start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        k++;
      end
    end
    check("done_cycle", done_at, v.exp_done);
    check("abc_sequence_errors", seq_err, 0);
    check("end_busy", int'(busy_v[i]), 0);
    check("end_abc",  int'(abc_v[i]),  7);
    check("end_err",  int'(err_v[i]),  int'(v.exp_err));
    check("end_fail", int'(fail_v[i]), int'(v.exp_fail));
    check("end_pass", int'(pass_v[i]), int'(v.exp_pass));
    @(posedge clk);
    #1;
    check("done_hold", int'(done_v[i]), 1);
    check("pass_hold", int'(pass_v[i]), int'(v.exp_pass));
  endtask

  sweep_t vec [5];

  initial begin
    vec[0] = '{inst: 0, hold: 20, start_again_at: -1, exp_done: 168, exp_err: 4'd0, exp_fail: 8'h00, exp_pass: 1'b1};
    vec[1] = '{inst: 1, hold: 20, start_again_at: -1, exp_done: 168, exp_err: 4'd2, exp_fail: 8'h81, exp_pass: 1'b0};
    vec[2] = '{inst: 1, hold: 20, start_again_at: -1, exp_done: 168, exp_err: 4'd2, exp_fail: 8'h81, exp_pass: 1'b0};
    vec[3] = '{inst: 2, hold: 1,  start_again_at: -1, exp_done: 16,  exp_err: 4'd0, exp_fail: 8'h00, exp_pass: 1'b1};
    vec[4] = '{inst: 0, hold: 20, start_again_at: 50, exp_done: 168, exp_err: 4'd0, exp_fail: 8'h00, exp_pass: 1'b1};

    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_all_zero(i, "reset");
    rst = 1'b0;

    // Table of sweeps; vec[2] restarts instance 1 from DONE after a failing run
    for (int n = 0; n < 5; n++) run_sweep(vec[n]);

    // Reset together with start while instance 0 applies idx 3
    begin
      int k = 0;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      while (k < 63) begin
        @(posedge clk);
        #1;
        k++;
      end
      check("mid_abc_before_rst", int'(abc_v[0]), 3);
      rst = 1'b1;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      start_v[0] = 1'b0;
      check_all_zero(0, "mid_rst");
      repeat (3) @(posedge clk);
      #1;
      check("idle_after_rst_busy", int'(busy_v[0]), 0);
      check("idle_after_rst_abc",  int'(abc_v[0]),  0);
    end
    run_sweep(vec[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
